// File: rtl/alu_rr_arbiter_pkg.sv
// Shared opcode and FSM state definitions for the round-robin ALU arbiter.
// Both requesters and the ALU datapath agree on these opcode values.
package alu_rr_arbiter_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_ASR = 3'b101;
   localparam logic [2:0] ALU_LSR = 3'b110;
   localparam logic [2:0] ALU_BAD = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Purely combinational ALU: wrap-around add/sub, bitwise ops and right shifts.
// Unsupported opcodes yield zero; the caller flags them as errors.
module alu_rr_arbiter_alu
   import alu_rr_arbiter_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CTRL_W = 3
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = '0;
      case (ctrl)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         // Shift amounts at or beyond DATA_W fill entirely with the sign bit.
         ALU_ASR: y = $signed(a) >>> b;
         ALU_LSR: y = a >> b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester front end for one shared ALU: round-robin grant, one operation
// in flight, registered result returned with the issuing requester's id.
module alu_rr_arbiter
   import alu_rr_arbiter_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              busy
);

   state_e              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic                id_q, id_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_id_q, resp_id_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic                resp_err_q, resp_err_d;

   logic                grant0;
   logic                grant1;
   logic                op_bad;
   logic [DATA_W-1:0]   alu_y;

   alu_rr_arbiter_alu #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_alu (
      .a    (a_q),
      .b    (b_q),
      .ctrl (ctrl_q),
      .y    (alu_y)
   );

   // On contention the requester that did not win last time is favoured;
   // a lone requester always wins.
   assign grant0 = req0_valid & ~(req1_valid & ~last_grant_q);
   assign grant1 = req1_valid & ~(req0_valid &  last_grant_q);

   assign req0_ready = (state_q == IDLE) & grant0;
   assign req1_ready = (state_q == IDLE) & grant1;
   assign op_bad     = (ctrl_q == ALU_BAD);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      ctrl_d       = ctrl_q;
      id_d         = id_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         IDLE: begin
            if (grant0 | grant1) begin
               a_d          = grant1 ? req1_a    : req0_a;
               b_d          = grant1 ? req1_b    : req0_b;
               ctrl_d       = grant1 ? req1_ctrl : req0_ctrl;
               id_d         = grant1;
               last_grant_d = grant1;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            resp_data_d  = op_bad ? '0 : alu_y;
            resp_err_d   = op_bad;
            resp_id_d    = id_q;
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         ctrl_q       <= '0;
         id_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         ctrl_q       <= ctrl_d;
         id_q         <= id_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Randomised and directed checks of the round-robin ALU arbiter against a
// behavioural model of arithmetic results and grant order.
module tb_alu_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready;
   logic [7:0] req0_a, req0_b;
   logic [2:0] req0_ctrl;
   logic       req1_valid, req1_ready;
   logic [7:0] req1_a, req1_b;
   logic [2:0] req1_ctrl;
   logic       resp_valid, resp_ready, resp_id, resp_err, busy;
   logic [7:0] resp_data;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   alu_rr_arbiter #(.DATA_W(8), .CTRL_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ctrl  (req0_ctrl),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ctrl  (req1_ctrl),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   function automatic logic [7:0] model_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
      int ai, bi, sa, r;
      ai = int'(a);
      bi = int'(b);
      r  = 0;
      case (op)
         3'd0: r = (ai + bi) % 256;
         3'd1: r = (ai - bi + 256) % 256;
         3'd2: r = int'(a & b);
         3'd3: r = int'(a | b);
         3'd4: r = int'(a ^ b);
         3'd5: begin
            sa = (ai >= 128) ? ai - 256 : ai;
            r  = (bi >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> bi) & 255);
         end
         3'd6: r = (bi >= 8) ? 0 : (ai >> bi);
         default: r = 0;
      endcase
      return r[7:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Presents one request pair, waits for the response and completes the handshake.
   // lat counts edges from the accepting edge to resp_valid; -1 means no response.
   task automatic run_op(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [2:0] c0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic [2:0] c1,
                         output logic r0, output logic r1, output int lat,
                         output logic id, output logic [7:0] data, output logic err);
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
      resp_ready = 1'b1;
      #1;
      r0 = req0_ready;
      r1 = req1_ready;
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (resp_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      id   = resp_id;
      data = resp_data;
      err  = resp_err;
      if (lat > 0) step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      $display("[TB] op v0=%0d v1=%0d rdy0=%0d rdy1=%0d id=%0d data=%02h err=%0d lat=%0d",
               v0, v1, r0, r1, id, data, err, lat);
   endtask

   task automatic test_reset();
      pulse_reset();
      #1;
      tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid got=%0d exp=0", resp_valid); end
      tests_run++; if (resp_data !== 8'h00) begin tests_failed++; $display("FAIL reset_resp_data got=%02h exp=00", resp_data); end
      tests_run++; if (resp_id !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_id got=%0d exp=0", resp_id); end
      tests_run++; if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_err got=%0d exp=0", resp_err); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%0d exp=0", busy); end
      tests_run++; if ({req0_ready, req1_ready} !== 2'b00) begin tests_failed++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
   endtask

   task automatic test_single_add();
      logic r0, r1, id, err;
      logic [7:0] data;
      int lat;
      run_op(1'b1, 8'h05, 8'h03, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, r0, r1, lat, id, data, err);
      tests_run++; if ({r0, r1} !== 2'b10) begin tests_failed++; $display("FAIL add_ready got=%b exp=10", {r0, r1}); end
      tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL add_latency got=%0d exp=2", lat); end
      tests_run++; if (data !== 8'h08) begin tests_failed++; $display("FAIL add_data got=%02h exp=08", data); end
      tests_run++; if ({id, err} !== 2'b00) begin tests_failed++; $display("FAIL add_id_err got=%b exp=00", {id, err}); end
   endtask

   task automatic test_alternation();
      logic r0, r1, id, err, v0, v1, w, last;
      logic [7:0] data, a0, b0, a1, b1, exp_d;
      logic [2:0] c0, c1;
      int lat;
      pulse_reset();
      for (int k = 0; k < 2; k++) begin
         run_op(1'b1, 8'h10, 8'h01, 3'd1, 1'b1, 8'hF0, 8'hFF, 3'd4, r0, r1, lat, id, data, err);
         tests_run++; if (id !== k[0]) begin tests_failed++; $display("FAIL both_first_id got=%0d exp=%0d", id, k[0]); end
         tests_run++; if (data !== 8'h0F) begin tests_failed++; $display("FAIL both_first_data got=%02h exp=0F", data); end
      end
      last = 1'b1;
      for (int k = 0; k < 24; k++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (k < 8) begin v0 = 1'b1; v1 = 1'b1; end
         if (!v0 && !v1) v0 = 1'b1;
         a0 = 8'($urandom); b0 = 8'($urandom); c0 = 3'($urandom_range(0, 7));
         a1 = 8'($urandom); b1 = 8'($urandom); c1 = 3'($urandom_range(0, 7));
         w = (v0 && v1) ? ~last : v1;
         exp_d = w ? model_alu(a1, b1, c1) : model_alu(a0, b0, c0);
         run_op(v0, a0, b0, c0, v1, a1, b1, c1, r0, r1, lat, id, data, err);
         tests_run++; if ({r1, r0} !== {w, ~w}) begin tests_failed++; $display("FAIL rr_grant got=%b exp=%b", {r1, r0}, {w, ~w}); end
         tests_run++; if (id !== w) begin tests_failed++; $display("FAIL rr_id got=%0d exp=%0d", id, w); end
         tests_run++; if (data !== exp_d) begin tests_failed++; $display("FAIL rr_data got=%02h exp=%02h", data, exp_d); end
         tests_run++; if (err !== ((w ? c1 : c0) == 3'd7)) begin tests_failed++; $display("FAIL rr_err got=%0d exp=%0d", err, (w ? c1 : c0) == 3'd7); end
         tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL rr_latency got=%0d exp=2", lat); end
         last = w;
      end
   endtask

   task automatic test_back_to_back_stall();
      int bad_stable, bad_ready, bad_busy;
      pulse_reset();
      req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h0F; req1_ctrl = 3'd2;
      resp_ready = 1'b0;
      step();
      step();
      tests_run++; if (resp_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_resp_valid got=%0d exp=1", resp_valid); end
      req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_ctrl = 3'd0;
      bad_stable = 0; bad_ready = 0; bad_busy = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if ({resp_valid, resp_id, resp_err, resp_data} !== {1'b1, 1'b1, 1'b0, 8'h0A}) bad_stable++;
         if ({req0_ready, req1_ready} !== 2'b00) bad_ready++;
         if (busy !== 1'b1) bad_busy++;
      end
      $display("[TB] stall 5 cycles data=%02h id=%0d", resp_data, resp_id);
      tests_run++; if (bad_stable !== 0) begin tests_failed++; $display("FAIL stall_resp_stable got=%0d exp=0 unstable cycles", bad_stable); end
      tests_run++; if (bad_ready !== 0) begin tests_failed++; $display("FAIL stall_ready_low got=%0d exp=0 cycles with ready", bad_ready); end
      tests_run++; if (bad_busy !== 0) begin tests_failed++; $display("FAIL stall_busy got=%0d exp=0 cycles not busy", bad_busy); end
      resp_ready = 1'b1;
      step();
      tests_run++; if ({resp_valid, busy} !== 2'b00) begin tests_failed++; $display("FAIL stall_release got=%b exp=00", {resp_valid, busy}); end
      tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL stall_next_grant got=%b exp=10", {req0_ready, req1_ready}); end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_arith_edges();
      logic r0, r1, id, err;
      logic [7:0] data;
      logic [7:0] ta [4] = '{8'hFF, 8'h00, 8'hF0, 8'hF0};
      logic [7:0] tb_ [4] = '{8'h02, 8'h01, 8'h3C, 8'h0F};
      logic [2:0] tc [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
      logic [7:0] te [4] = '{8'h01, 8'hFF, 8'h30, 8'hFF};
      int lat;
      for (int k = 0; k < 4; k++) begin
         run_op(1'b1, ta[k], tb_[k], tc[k], 1'b0, 8'h00, 8'h00, 3'd0, r0, r1, lat, id, data, err);
         tests_run++; if (data !== te[k]) begin tests_failed++; $display("FAIL edge_op%0d got=%02h exp=%02h", k, data, te[k]); end
      end
   endtask

   task automatic test_bad_opcode();
      logic r0, r1, id, err;
      logic [7:0] data;
      int lat;
      run_op(1'b1, 8'h12, 8'h34, 3'd7, 1'b0, 8'h00, 8'h00, 3'd0, r0, r1, lat, id, data, err);
      tests_run++; if ({err, data} !== {1'b1, 8'h00}) begin tests_failed++; $display("FAIL bad_op got err=%0d data=%02h exp err=1 data=00", err, data); end
      run_op(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h01, 8'h01, 3'd0, r0, r1, lat, id, data, err);
      tests_run++; if ({err, data, id} !== {1'b0, 8'h02, 1'b1}) begin tests_failed++; $display("FAIL after_bad got err=%0d data=%02h id=%0d exp err=0 data=02 id=1", err, data, id); end
   endtask

   task automatic test_reset_mid_op();
      logic r0, r1, id, err;
      logic [7:0] data;
      int lat, seen;
      run_op(1'b1, 8'h01, 8'h02, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, r0, r1, lat, id, data, err);
      req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04; req0_ctrl = 3'd0;
      req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h06; req1_ctrl = 3'd0;
      #1;
      tests_run++; if ({req0_ready, req1_ready} !== 2'b01) begin tests_failed++; $display("FAIL pre_reset_grant got=%b exp=01", {req0_ready, req1_ready}); end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++; if ({resp_valid, busy} !== 2'b00) begin tests_failed++; $display("FAIL mid_reset_state got=%b exp=00", {resp_valid, busy}); end
      #1;
      tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL post_reset_grant got=%b exp=10", {req0_ready, req1_ready}); end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (resp_valid !== 1'b0) seen++;
      end
      $display("[TB] reset mid-op, stray responses=%0d", seen);
      tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL dropped_txn got=%0d exp=0 responses", seen); end
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
      resp_ready = 1'b1;
      test_reset();
      test_single_add();
      test_alternation();
      test_back_to_back_stall();
      test_arith_edges();
      test_bad_opcode();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
